// File: rtl/adc_sample_averager_pkg.sv
// Shared definitions for the ADC averaging front end and the temperature stage.
package adc_sample_averager_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } avg_state_e;

endpackage

// File: rtl/adc_sample_averager_if.sv
// Start/ready conversion handshake between the averager (master) and the ADC (slave).
interface adc_sample_averager_if;
  import adc_sample_averager_pkg::*;

  logic             conv_start;
  logic             adc_ready;
  logic [ADC_W-1:0] adc_data;

  modport master (output conv_start, input adc_ready, input adc_data);
  modport slave  (input conv_start, output adc_ready, output adc_data);
endinterface

// File: rtl/adc_sample_averager_rate_ticker.sv
// Free-running 0..SAMPLE_DIV-1 divider; held at zero while disabled, tick on the last count.
module adc_sample_averager_rate_ticker #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clock,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(SAMPLE_DIV - 1));
  assign tick_o = en_i && last;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i)     cnt_d = '0;
    else if (last) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Paces ADC conversions and block-averages 2^LOG2_N samples into one 12-bit word.
module adc_sample_averager
  import adc_sample_averager_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000,
  parameter int LOG2_N     = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enable,
  adc_sample_averager_if.master adc,
  output logic [ADC_W-1:0]      avg_out,
  output logic                  avg_valid,
  output logic                  timeout_err
);

  localparam int ACC_W = ADC_W + LOG2_N;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  avg_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADC_W-1:0]  avg_q, avg_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              en_prev_q;
  logic              tick;

  function automatic logic [ADC_W-1:0] trunc_avg(input logic [ACC_W-1:0] a);
    return a[ACC_W-1:LOG2_N];
  endfunction

  adc_sample_averager_rate_ticker #(.SAMPLE_DIV(SAMPLE_DIV)) u_ticker (
    .clock (clock),
    .rst   (rst),
    .en_i  (enable),
    .tick_o(tick)
  );

  assign acc_sum = acc_q + ACC_W'(adc.adc_data);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    avg_d   = avg_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    if (enable && !en_prev_q) err_d = 1'b0;
    if (!enable) begin
      // Dropping enable abandons any in-flight request and the partial block.
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (tick) state_d = ST_REQ;
        ST_REQ: begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end
        ST_WAIT: begin
          // A sample arriving on the expiry cycle still counts; ready wins.
          if (adc.adc_ready) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
              avg_d   = trunc_avg(acc_sum);
              vld_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            tmo_d   = tmo_q + 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_DONE: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    start_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      avg_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      avg_q     <= avg_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      start_q   <= start_d;
      en_prev_q <= enable;
    end
  end

  assign adc.conv_start = start_q;
  assign avg_out        = avg_q;
  assign avg_valid      = vld_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager with a 2-cycle-latency ADC model.
module tb_adc_sample_averager;

  logic        clock;
  logic        rst;
  logic        enable;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        timeout_err;

  adc_sample_averager_if adc_if ();

  adc_sample_averager #(.SAMPLE_DIV(4), .LOG2_N(3), .TIMEOUT(5)) dut (
    .clock      (clock),
    .rst        (rst),
    .enable     (enable),
    .adc        (adc_if),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] samp_q[$];
  logic [11:0] exp_q[$];
  int pend = 0;
  int req_n = 0;
  int mute_at = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic [11:0] val, input int k);
    for (int i = 0; i < k; i++) samp_q.push_back(val);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!adc_if.conv_start && n < 40);
    if (!adc_if.conv_start) begin
      chk("start_timeout", adc_if.conv_start, 1);
      n = -1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // ADC model: answers each request two cycles later from samp_q; request mute_at stays silent.
  initial begin
    adc_if.adc_ready = 1'b0;
    adc_if.adc_data  = '0;
    forever begin
      @(negedge clock);
      adc_if.adc_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && samp_q.size() > 0) begin
          adc_if.adc_ready = 1'b1;
          adc_if.adc_data  = samp_q.pop_front();
        end
      end
      if (adc_if.conv_start) begin
        req_n++;
        if (req_n != mute_at) pend = 2;
      end
    end
  end

  // Output monitor: every avg_valid pops one expected average.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clock);
      if (avg_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexp_vld", avg_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("avg_out", avg_out, e);
        end
        @(negedge clock);
        chk("vld_width", avg_valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap_cnt;
    rst    = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_start", adc_if.conv_start, 0);
    chk("rst_vld",   avg_valid, 0);
    chk("rst_avg",   avg_out, 0);
    chk("rst_err",   timeout_err, 0);
    rst = 1'b1;
    repeat (2) @(negedge clock);

    // Block 1: 0..7 -> 28>>3 = 3, plus request pacing.
    for (int i = 0; i < 8; i++) samp_q.push_back(12'(i));
    exp_q.push_back(12'd3);
    enable = 1'b1;
    wait_start(n);
    chk("first_start", n, 4);
    @(negedge clock);
    chk("start_width", adc_if.conv_start, 0);
    wait_start(n);
    chk("start_spacing", n + 1, 4);
    wait_drain();
    enable = 1'b0;
    repeat (10) @(negedge clock);
    chk("avg_hold", avg_out, 12'd3);
    chk("err_clean", timeout_err, 0);

    // Full-scale block then a small block, streamed back to back.
    push_block(12'hFFF, 8);
    push_block(12'h010, 8);
    exp_q.push_back(12'hFFF);
    exp_q.push_back(12'h010);
    enable = 1'b1;
    wait_drain();
    enable = 1'b0;
    repeat (3) @(negedge clock);

    // Timeout on the 3rd request; the two 0xFFF partials must be discarded.
    req_n   = 0;
    mute_at = 3;
    push_block(12'hFFF, 2);
    push_block(12'h100, 8);
    exp_q.push_back(12'h100);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) wait_start(n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!timeout_err && n < 20);
    chk("tmo_latency", n, 6);
    wait_drain();
    mute_at = 0;
    chk("err_sticky", timeout_err, 1);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    chk("err_hold_dis", timeout_err, 1);

    // Re-enable clears the error; 5 samples then an enable gap discards them.
    push_block(12'hFFF, 5);
    enable = 1'b1;
    @(negedge clock);
    chk("err_clear", timeout_err, 0);
    n = 0;
    while (samp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("partial_fed", samp_q.size(), 0);
    @(negedge clock);
    enable  = 1'b0;
    gap_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (avg_valid) gap_cnt++;
    end
    chk("gap_vld", gap_cnt, 0);
    push_block(12'h020, 8);
    exp_q.push_back(12'h020);
    enable = 1'b1;
    wait_drain();
    enable = 1'b0;
    repeat (3) @(negedge clock);

    // Reset while waiting on the 4th conversion; its ready lands inside reset.
    push_block(12'h040, 4);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) wait_start(n);
    @(negedge clock);
    rst = 1'b0;
    #1;
    chk("mid_rst_start", adc_if.conv_start, 0);
    chk("mid_rst_vld",   avg_valid, 0);
    chk("mid_rst_avg",   avg_out, 0);
    chk("mid_rst_err",   timeout_err, 0);
    @(negedge clock);
    @(negedge clock);
    chk("in_rst_avg", avg_out, 0);
    chk("in_rst_vld", avg_valid, 0);
    push_block(12'h080, 8);
    exp_q.push_back(12'h080);
    rst = 1'b1;
    wait_start(n);
    chk("rst_restart", n, 4);
    wait_drain();
    enable = 1'b0;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Upstream conditioning stage for the temperature path.
- Paces 12-bit ADC conversions at a fixed sample rate using a start/ready handshake with the converter.
- Block-averages 2^LOG2_N accepted samples and presents one averaged 12-bit word with a one-cycle valid strobe.
- The temperature-conversion stage consumes that word in place of the raw ADC input.

Parameters:
- SAMPLE_DIV, 1000: clock cycles between conversion requests (≥2).
- LOG2_N, 3: log2 of samples per average (1..6).
- TIMEOUT, 255: max cycles in WAIT for adc_ready before abort (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run control; low = idle and clear partial block.
- conv_start  out  1  one-cycle pulse requesting an ADC conversion.
- adc_ready  in  1  one-cycle strobe from ADC; adc_data valid in the same cycle.
- adc_data  in  12  raw conversion result.
- avg_out  out  12  latest averaged sample; holds between updates.
- avg_valid  out  1  one-cycle pulse when avg_out updates.
- timeout_err  out  1  sticky; set on conversion timeout.

Behaviour:
- Reset (rst=0, async) values:
  - FSM=IDLE; conv_start=0, avg_valid=0, avg_out=0, timeout_err=0.
  - Accumulator, sample count, pace counter and timeout counter all 0.
- Pace counter, while enable=1:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick=1 in the cycle the count equals SAMPLE_DIV-1.
  - While enable=0 the counter is held at 0.
- IDLE:
  - tick & enable → REQ.
  - A tick in any other state is dropped; no queuing.
- REQ:
  - conv_start=1 for exactly this cycle; conv_start is a registered output.
  - First conv_start appears the cycle after tick.
  - Always → WAIT, with the timeout counter cleared.
- WAIT, on adc_ready=1:
  - acc += adc_data; count += 1.
  - If count was 2^LOG2_N-1 → DONE, else → IDLE.
- WAIT, without adc_ready:
  - Timeout counter increments each cycle.
  - On reaching TIMEOUT: timeout_err=1, acc=0, count=0 (partial block discarded) → IDLE.
- DONE:
  - avg_out = acc >> LOG2_N (truncating); avg_valid=1 this cycle only.
  - acc and count cleared → IDLE.
  - avg_valid therefore rises the cycle after the last sample's adc_ready.
- Width rules:
  - Accumulator is 12+LOG2_N bits and cannot overflow.
  - Truncation only, no rounding.
- adc_ready outside WAIT: ignored; no accumulation, no error.
- enable falling in any state:
  - Next clock: FSM=IDLE, acc/count/timeout cleared.
  - avg_out and timeout_err hold.
  - A conv_start already issued is abandoned; a late adc_ready is ignored.
- timeout_err clears only on reset or a rising edge of enable.
- Same-cycle adc_ready and timeout expiry: adc_ready wins; the sample is accepted and no error is set.
- Reset mid-block: all state cleared immediately, asynchronously. The first tick after release occurs SAMPLE_DIV cycles after enable is seen high.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, REQ, WAIT, DONE).
  - ADC_W=12 constant, used by this block and the temperature stage.
- Natural sub-module: rate_ticker (parameterised SAMPLE_DIV divider with enable/clear and a tick output).
- Accumulation and FSM stay in this module.

Test Plan (bench: SAMPLE_DIV=4, LOG2_N=3, TIMEOUT=5; ADC model answers 2 cycles after conv_start):
- Reset then enable=1 → first conv_start 4 cycles after enable; pulse width 1; spacing between conv_starts is 4 cycles.
- Samples 0,1,2,3,4,5,6,7 → after the 8th adc_ready, avg_valid for 1 cycle with avg_out=3 (28>>3); avg_out holds 3 afterwards.
- Eight samples of 0xFFF → avg_out=0xFFF with no wrap; next block of eight 0x010 → avg_out=0x010.
- ADC model mutes on the 3rd request → timeout_err=1 five cycles after WAIT entry. Next 8 good samples of 0x100 → avg_out=0x100, i.e. the partial block was discarded. timeout_err stays 1 until enable toggles 0→1.
- enable=0 after 5 samples, then enable=1, then 8 samples of 0x020 → avg_out=0x020; no avg_valid during the gap.
- Assert rst low while in WAIT, with adc_ready arriving during reset → all outputs 0 immediately; no accumulation; operation restarts cleanly after release.
